pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch / multi-cycle MUL-DIV hazard control with watchdog
// and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_IFID,
    input  logic [4:0]       rs2_IFID,
    input  logic             use_rs1_IFID,
    input  logic             use_rs2_IFID,
    input  logic [4:0]       rd_IDEX,
    input  logic             MemRead_IDEX,
    input  logic             md_start_IDEX,
    input  logic             md_done,
    input  logic             branch_taken_EX,
    input  logic             cnt_clear,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             EX_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             md_timeout
);
    localparam logic [1:0] RUN = 2'd0, LU_STALL = 2'd1, MD_BUSY = 2'd2;
    localparam int WD_W = $clog2(MD_MAX_CYCLES + 1);
    logic [1:0] state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic timeout_q, timeout_d, wd_fire, lu, stall, hold, bubble, flush;
    assign lu = MemRead_IDEX && rd_IDEX != 5'd0 &&
                ((use_rs1_IFID && rd_IDEX == rs1_IFID) || (use_rs2_IFID && rd_IDEX == rs2_IFID));
    assign wd_inc = wd_q + WD_W'(1);
    assign wd_fire = state_q == MD_BUSY && !md_done && wd_inc == WD_W'(MD_MAX_CYCLES);
    always_comb begin
        state_d = state_q;
        wd_d = wd_q;
        stall = 1'b0;
        hold = 1'b0;
        bubble = 1'b0;
        flush = 1'b0;
        case (state_q)
            RUN:
                if (branch_taken_EX) begin
                    flush = 1'b1;
                    bubble = 1'b1;
                end else if (md_start_IDEX) begin
                    stall = 1'b1;
                    hold = 1'b1;
                    wd_d = WD_W'(1);
                    state_d = MD_BUSY;
                end else if (lu) begin
                    stall = 1'b1;
                    bubble = 1'b1;
                    state_d = LU_STALL;
                end
            MD_BUSY:
                if (md_done) begin
                    wd_d = '0;
                    state_d = RUN;
                end else begin
                    stall = 1'b1;
                    hold = 1'b1;
                    wd_d = wd_fire ? '0 : wd_inc;
                    state_d = wd_fire ? RUN : MD_BUSY;
                end
            default: state_d = RUN;
        endcase
    end
    // reset forces idle outputs even while the async reset is still held
    assign PCWrite = rst || !stall;
    assign IFIDWrite = rst || !stall;
    assign IDEX_bubble = !rst && bubble;
    assign IFID_flush = !rst && flush;
    assign EX_hold = !rst && hold;
    assign stall_cnt_d = cnt_clear ? '0 : (!PCWrite && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign flush_cnt_d = cnt_clear ? '0 : (IFID_flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    assign timeout_d = cnt_clear ? 1'b0 : timeout_q || wd_fire;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wd_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q <= wd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign md_timeout = timeout_q;
endmodule
